// File: rtl/instr_pkg.sv
// Shared definitions for the instruction sequencer: instruction fields,
// opcodes, the bubble word and the issue FSM states.
package instr_pkg;

  localparam int unsigned IW = 17;
  localparam int unsigned RW = 5;

  localparam int unsigned OP_MSB  = 16;
  localparam int unsigned OP_LSB  = 15;
  localparam int unsigned WA_MSB  = 14;
  localparam int unsigned WA_LSB  = 10;
  localparam int unsigned RA1_MSB = 9;
  localparam int unsigned RA1_LSB = 5;
  localparam int unsigned RA2_MSB = 4;
  localparam int unsigned RA2_LSB = 0;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_SUB = 2'b01;
  localparam opcode_t OP_SLT = 2'b10;
  localparam opcode_t OP_SW  = 2'b11;

  // add r0 <- r0 + r0: harmless because r0 is hard-wired to zero
  localparam logic [IW-1:0] BUBBLE = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STALL,
    ST_DONE
  } state_e;

  function automatic logic writes_reg(input opcode_t op);
    return op != OP_SW;
  endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Remembers the destination registers of the last HAZ_DIST issue slots and
// flags a read-after-write hazard for the candidate instruction.
module hazard_tracker
  import instr_pkg::*;
#(
  parameter int unsigned HAZ_DIST = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          shift_i,
  input  logic          push_i,
  input  opcode_t       op_i,
  input  logic [RW-1:0] wa_i,
  input  logic [RW-1:0] ra1_i,
  input  logic [RW-1:0] ra2_i,
  output logic          hazard_o
);

  logic [HAZ_DIST-1:0] vld_q;
  logic [RW-1:0]       wa_q [HAZ_DIST];
  logic                entry_vld_d;

  // Writes to r0 never block a reader, so they enter as invalid slots
  assign entry_vld_d = push_i && writes_reg(op_i) && (wa_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < HAZ_DIST; i++) wa_q[i] <= '0;
    end else if (clear_i) begin
      vld_q <= '0;
    end else if (shift_i) begin
      for (int unsigned i = HAZ_DIST - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        wa_q[i]  <= wa_q[i-1];
      end
      vld_q[0] <= entry_vld_d;
      wa_q[0]  <= wa_i;
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int unsigned i = 0; i < HAZ_DIST; i++) begin
      if (vld_q[i] && ((wa_q[i] == ra1_i) || (wa_q[i] == ra2_i))) hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction issue unit: loadable program memory, PC stepping and
// hazard-driven bubble insertion feeding the datapath instruction bus.
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned HAZ_DIST = 2
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          Load_we,
  input  logic [AW-1:0] Load_addr,
  input  logic [IW-1:0] Load_data,
  input  logic          Start,
  input  logic [AW:0]   Len,
  output logic [IW-1:0] Instruccion,
  output logic          Valid,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Done
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic [AW:0]   rem_q, rem_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          mem_we;
  logic          hist_clear, hist_shift, hist_push;
  logic          hazard;
  logic [IW-1:0] cand;
  logic [IW-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[Load_addr] <= Load_data;
  end

  assign cand = mem_q[pc_q];

  hazard_tracker #(
    .HAZ_DIST(HAZ_DIST)
  ) u_hazard_tracker (
    .clk_i   (CLK),
    .rst_ni  (RST_n),
    .clear_i (hist_clear),
    .shift_i (hist_shift),
    .push_i  (hist_push),
    .op_i    (cand[OP_MSB:OP_LSB]),
    .wa_i    (cand[WA_MSB:WA_LSB]),
    .ra1_i   (cand[RA1_MSB:RA1_LSB]),
    .ra2_i   (cand[RA2_MSB:RA2_LSB]),
    .hazard_o(hazard)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    rem_d      = rem_q;
    instr_d    = BUBBLE;
    valid_d    = 1'b0;
    busy_d     = (state_q != ST_IDLE);
    done_d     = 1'b0;
    mem_we     = 1'b0;
    hist_clear = 1'b0;
    hist_shift = 1'b0;
    hist_push  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        mem_we = Load_we;
        if (Start) begin
          rem_d      = Len;
          pc_d       = '0;
          pc_out_d   = '0;
          hist_clear = 1'b1;
          state_d    = (Len == '0) ? ST_DONE : ST_RUN;
        end
      end
      // RUN and STALL share one evaluation; the history shifts every slot
      // so a stalled reader waits out the producer's distance naturally.
      ST_RUN, ST_STALL: begin
        hist_shift = 1'b1;
        pc_out_d   = pc_q;
        if (hazard) begin
          state_d = ST_STALL;
        end else begin
          instr_d   = cand;
          valid_d   = 1'b1;
          hist_push = 1'b1;
          pc_d      = pc_q + AW'(1);
          rem_d     = rem_q - (AW+1)'(1);
          state_d   = (rem_q == (AW+1)'(1)) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      rem_q    <= '0;
      instr_q  <= BUBBLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      rem_q    <= rem_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Instruccion = instr_q;
  assign Valid       = valid_q;
  assign PC          = pc_out_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: issue order, hazard bubbles, Done
// timing, ignored commands during a run and mid-run reset.
module tb_instr_sequencer;

  localparam logic [16:0] BUB = 17'h00000;

  logic        CLK;
  logic        RST_n;
  logic        Load_we;
  logic [4:0]  Load_addr;
  logic [16:0] Load_data;
  logic        Start;
  logic [5:0]  Len;
  logic [16:0] Instruccion;
  logic        Valid;
  logic [4:0]  PC;
  logic        Busy;
  logic        Done;

  int nvec = 0;
  int nerr = 0;

  instr_sequencer #(
    .DEPTH   (32),
    .AW      (5),
    .HAZ_DIST(2)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .Load_we    (Load_we),
    .Load_addr  (Load_addr),
    .Load_data  (Load_data),
    .Start      (Start),
    .Len        (Len),
    .Instruccion(Instruccion),
    .Valid      (Valid),
    .PC         (PC),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [16:0] mk(input logic [1:0] op, input logic [4:0] wa,
                                     input logic [4:0] ra1, input logic [4:0] ra2);
    return {op, wa, ra1, ra2};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [16:0] ins,
                            input logic d);
    chk({tag, ".Valid"}, 32'(Valid), 32'(v));
    chk({tag, ".Instr"}, 32'(Instruccion), 32'(ins));
    chk({tag, ".Done"}, 32'(Done), 32'(d));
  endtask

  task automatic issue(input string tag, input logic [4:0] pc, input logic [16:0] ins);
    expect_out(tag, 1'b1, ins, 1'b0);
    chk({tag, ".PC"}, 32'(PC), 32'(pc));
    chk({tag, ".Busy"}, 32'(Busy), 32'(1'b1));
  endtask

  task automatic bubble(input string tag, input logic [4:0] pc);
    expect_out(tag, 1'b0, BUB, 1'b0);
    chk({tag, ".PC"}, 32'(PC), 32'(pc));
  endtask

  task automatic load(input logic [4:0] a, input logic [16:0] d);
    Load_we   = 1'b1;
    Load_addr = a;
    Load_data = d;
    tick();
    Load_we   = 1'b0;
  endtask

  task automatic run(input logic [5:0] n);
    Start = 1'b1;
    Len   = n;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    RST_n     = 1'b0;
    Load_we   = 1'b0;
    Load_addr = '0;
    Load_data = '0;
    Start     = 1'b0;
    Len       = '0;
    #12;
    expect_out("rst", 1'b0, BUB, 1'b0);
    chk("rst.PC", 32'(PC), 32'd0);
    chk("rst.Busy", 32'(Busy), 32'd0);
    RST_n = 1'b1;
    tick();

    // Independent instructions stream back to back
    load(5'd0, mk(2'b00, 5'd4, 5'd1, 5'd2));
    load(5'd1, mk(2'b01, 5'd5, 5'd2, 5'd3));
    load(5'd2, mk(2'b10, 5'd6, 5'd3, 5'd1));
    run(6'd3);
    tick(); issue("t1.i0", 5'd0, mk(2'b00, 5'd4, 5'd1, 5'd2));
    tick(); issue("t1.i1", 5'd1, mk(2'b01, 5'd5, 5'd2, 5'd3));
    tick(); issue("t1.i2", 5'd2, mk(2'b10, 5'd6, 5'd3, 5'd1));
    tick(); expect_out("t1.done", 1'b0, BUB, 1'b1);
    tick(); expect_out("t1.post", 1'b0, BUB, 1'b0);
    chk("t1.post.Busy", 32'(Busy), 32'd0);

    // Back-to-back dependency costs two bubbles
    load(5'd0, mk(2'b00, 5'd4, 5'd1, 5'd2));
    load(5'd1, mk(2'b01, 5'd7, 5'd4, 5'd3));
    run(6'd2);
    tick(); issue("t2.i0", 5'd0, mk(2'b00, 5'd4, 5'd1, 5'd2));
    tick(); bubble("t2.b0", 5'd1);
    tick(); bubble("t2.b1", 5'd1);
    tick(); issue("t2.i1", 5'd1, mk(2'b01, 5'd7, 5'd4, 5'd3));
    tick(); expect_out("t2.done", 1'b0, BUB, 1'b1);

    // Dependency two slots back costs one bubble
    load(5'd0, mk(2'b00, 5'd4, 5'd1, 5'd2));
    load(5'd1, mk(2'b01, 5'd5, 5'd1, 5'd2));
    load(5'd2, mk(2'b10, 5'd6, 5'd1, 5'd4));
    run(6'd3);
    tick(); issue("t3.i0", 5'd0, mk(2'b00, 5'd4, 5'd1, 5'd2));
    tick(); issue("t3.i1", 5'd1, mk(2'b01, 5'd5, 5'd1, 5'd2));
    tick(); bubble("t3.b0", 5'd2);
    tick(); issue("t3.i2", 5'd2, mk(2'b10, 5'd6, 5'd1, 5'd4));
    tick(); expect_out("t3.done", 1'b0, BUB, 1'b1);

    // Store WA and writes to r0 never create a hazard
    load(5'd0, mk(2'b11, 5'd7, 5'd1, 5'd2));
    load(5'd1, mk(2'b00, 5'd5, 5'd7, 5'd7));
    load(5'd2, mk(2'b00, 5'd0, 5'd1, 5'd2));
    load(5'd3, mk(2'b01, 5'd6, 5'd0, 5'd0));
    run(6'd4);
    tick(); issue("t4.i0", 5'd0, mk(2'b11, 5'd7, 5'd1, 5'd2));
    tick(); issue("t4.i1", 5'd1, mk(2'b00, 5'd5, 5'd7, 5'd7));
    tick(); issue("t4.i2", 5'd2, mk(2'b00, 5'd0, 5'd1, 5'd2));
    tick(); issue("t4.i3", 5'd3, mk(2'b01, 5'd6, 5'd0, 5'd0));
    tick(); expect_out("t4.done", 1'b0, BUB, 1'b1);

    // Len == 0: Done straight away, no instructions
    run(6'd0);
    tick(); expect_out("t5.done", 1'b0, BUB, 1'b1);
    tick(); expect_out("t5.post", 1'b0, BUB, 1'b0);
    chk("t5.post.Busy", 32'(Busy), 32'd0);

    // Start and Load_we held during a run are ignored
    run(6'd2);
    Start     = 1'b1;
    Len       = 6'd5;
    Load_we   = 1'b1;
    Load_addr = 5'd1;
    Load_data = mk(2'b11, 5'd1, 5'd1, 5'd1);
    tick(); issue("t6.i0", 5'd0, mk(2'b11, 5'd7, 5'd1, 5'd2));
    tick(); issue("t6.i1", 5'd1, mk(2'b00, 5'd5, 5'd7, 5'd7));
    tick(); expect_out("t6.done", 1'b0, BUB, 1'b1);
    Start   = 1'b0;
    Load_we = 1'b0;
    tick(); expect_out("t6.post", 1'b0, BUB, 1'b0);
    chk("t6.post.Busy", 32'(Busy), 32'd0);

    // Reset mid-run aborts, then a fresh run starts from PC 0
    run(6'd4);
    tick(); issue("t7.i0", 5'd0, mk(2'b11, 5'd7, 5'd1, 5'd2));
    tick(); issue("t7.i1", 5'd1, mk(2'b00, 5'd5, 5'd7, 5'd7));
    #2;
    RST_n = 1'b0;
    #1;
    expect_out("t7.rst", 1'b0, BUB, 1'b0);
    chk("t7.rst.PC", 32'(PC), 32'd0);
    chk("t7.rst.Busy", 32'(Busy), 32'd0);
    #3;
    RST_n = 1'b1;
    tick(); expect_out("t7.idle", 1'b0, BUB, 1'b0);
    run(6'd2);
    tick(); issue("t7.r0", 5'd0, mk(2'b11, 5'd7, 5'd1, 5'd2));
    tick(); issue("t7.r1", 5'd1, mk(2'b00, 5'd5, 5'd7, 5'd7));
    tick(); expect_out("t7.done", 1'b0, BUB, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction issue unit that drives the 17-bit instruction bus of the pipelined datapath: it holds a loadable program, steps a program counter, and presents one instruction per clock. It inserts bubbles on read-after-write hazards, because a write reaches the register file only after the two pipeline buffers. It is the producer of the datapath's instruction stream and replaces the hand-driven stimulus at the top level.

## Interface
- DEPTH, 32, program memory words
- AW, 5, PC/address width (log2 DEPTH)
- HAZ_DIST, 2, issue slots a written register stays unreadable after its producer issues
- CLK  in  1  clock, rising edge
- RST_n  in  1  asynchronous, active-low reset
- Load_we  in  1  program write strobe (honoured in IDLE only)
- Load_addr  in  AW  program write address
- Load_data  in  17  program word
- Start  in  1  begin run (honoured in IDLE only)
- Len  in  AW+1  instruction count, sampled with Start
- Instruccion  out  17  to datapath: [16:15] OpCode, [14:10] WA, [9:5] RA1, [4:0] RA2
- Valid  out  1  Instruccion is a program instruction, not a bubble
- PC  out  AW  address of instruction currently on Instruccion
- Busy  out  1  run in progress
- Done  out  1  one-cycle pulse at end of run

## Operation
- Opcodes: 00 add, 01 sub, 10 slt write WA; 11 store writes no register.
- BUBBLE = 17'h00000 (add r0 <- r0 + r0); r0 is constant zero, so a bubble has no effect.
- FSM states: IDLE, RUN, STALL, DONE.
  - IDLE: outputs BUBBLE. Load_we writes mem[Load_addr] <= Load_data. Start latches Len and clears PC and history. Go to DONE if Len == 0, else RUN.
  - RUN: candidate = mem[PC].
    - Hazard: candidate RA1 or RA2 equals a valid history WA, and that WA != 0. On hazard: issue BUBBLE with Valid=0, hold PC, go to STALL.
    - No hazard: issue candidate with Valid=1, PC+1, remaining-1. When remaining reaches 0, go to DONE.
  - STALL: re-evaluates the same candidate each cycle. Behaves like RUN, but stays in STALL while the hazard persists.
  - DONE: Done=1 for one cycle, output BUBBLE, return to IDLE.
- History: HAZ_DIST-deep shift register of {valid, WA}, shifted every RUN/STALL cycle.
  - Entry pushed on issue of an op 00/01/10; entry valid only if WA != 0.
  - Bubbles and stores push invalid entries.
  - Longest stall is therefore HAZ_DIST cycles.
- Start or Load_we outside IDLE is ignored. No queuing.
- PC wraps modulo DEPTH when Len > DEPTH.
- Busy=1 in RUN, STALL and DONE.

## Timing
- Reset (async assert, sync release) values: Instruccion=BUBBLE, Valid=0, PC=0, Busy=0, Done=0; state IDLE; history cleared. Program memory is not reset.
- Reset mid-run aborts immediately. No Done pulse.
- All outputs are registered. Start sampled at edge k gives the first Instruccion after edge k+1.
- Program memory: combinational read at PC, synchronous write. A load at edge j is readable by a Start at edge j+1.
- Issue throughput: one instruction per cycle with no hazards.
- Each instruction stays on Instruccion for exactly one cycle. The datapath samples Instruccion every edge.
- Done asserts the cycle after the last issue.
- Len == 0: Done one cycle after Start; no Valid cycles.
- A hazard with the instruction issued immediately before costs HAZ_DIST bubbles. A hazard k slots back costs HAZ_DIST-k+1 bubbles.

## Structure
- Package instr_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_SLT/OP_SW
  - field bit ranges
  - BUBBLE
  - FSM state enum
  - function writes_reg(opcode)
- Sub-module hazard_tracker: history shift register plus compare logic.
  - Inputs: candidate RA1/RA2, push/op/WA.
  - Output: hazard.
- Top holds FSM, PC, counter, memory.

## Test plan
- Load 3 independent instructions (WA 4,5,6; reads of r1,r2,r3), Len=3 -> Valid high 3 consecutive cycles, PC 0,1,2, Done on 4th cycle.
- Add WA=4 then sub RA1=4 -> 2 bubble cycles (Valid=0, PC held at 1), then sub issues.
- Add WA=4, independent op, then slt RA2=4 -> exactly 1 bubble before slt.
- Store (WA field 7) then op reading r7; add WA=0 then op reading r0 -> no bubbles.
- Len=0 Start -> Done pulse next cycle, Instruccion stays BUBBLE; Start/Load_we during RUN -> ignored, memory unchanged.
- Assert RST_n low mid-run -> outputs at reset values immediately; restart with Len=2 runs from PC=0.
